xbar_out_port: RTL and testbench
================================

Name: xbar_out_port

Overview:
- Parametrised output-port controller for an N-master crossbar. One instance per slave port.
- Arbitrates among N master requests with a built-in round-robin arbiter and switches the winner's addr/cmd/wdata to the slave.
- Returns ack/rdata to the winning master only.
- Adds two behaviours over the fixed 4x32 generation: fairness across masters, and a slave-ack timeout with error reporting.

Parameters:
N_MASTERS, 4, number of requesting masters (2..16)
ADDR_W, 32, address width
DATA_W, 32, data width
TMO_W, 8, timeout counter width; timeout fires after 2**TMO_W-1 CONNECT cycles without s_ack

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
m_req  in  N_MASTERS  per-master request; held until that master's m_ack
m_addr  in  N_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
m_cmd  in  N_MASTERS  1=write, 0=read
m_wdata  in  N_MASTERS*DATA_W  packed write data
m_ack  out  N_MASTERS  one-hot completion to the granted master
m_err  out  N_MASTERS  timeout flag, valid with m_ack
m_rdata  out  N_MASTERS*DATA_W  read data, only the winner's slice is updated
s_req  out  1  slave request
s_addr  out  ADDR_W  slave address
s_cmd  out  1  slave command
s_wdata  out  DATA_W  slave write data
s_ack  in  1  slave completion
s_rdata  in  DATA_W  slave read data, valid with s_ack
grant  out  N_MASTERS  one-hot current owner; zero when idle
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - All outputs go to 0.
  - FSM goes to IDLE.
  - rr_ptr = 0; timeout counter = 0.
- All outputs are registered.
- FSM states: IDLE, CONNECT, RESP.
- IDLE:
  - If |m_req, pick the winner w = first set bit searching from rr_ptr upward, wrapping modulo N_MASTERS.
  - At that edge: grant[w]=1, s_req=1, s_addr/s_cmd/s_wdata latched from slice w, timeout counter cleared, go to CONNECT.
  - s_req rises 1 cycle after m_req is first sampled high.
- CONNECT:
  - s_* hold their latched values; the master may not change its fields.
  - Counter increments each cycle.
  - s_ack sampled high: s_req<=0, m_ack[w]<=1, m_err[w]<=0; if s_cmd=0, m_rdata slice w <= s_rdata. Go to RESP.
  - Counter reaching all-ones with no s_ack: s_req<=0, m_ack[w]<=1, m_err[w]<=1, m_rdata slice w unchanged. Go to RESP.
  - s_ack on the same edge the counter saturates: the ack wins, m_err=0.
  - Withdrawal of m_req[w] in CONNECT is a protocol violation and is ignored; the transaction completes.
- RESP:
  - m_ack/m_err held; s_ack ignored.
  - When m_req[w] is sampled low: m_ack, m_err and grant clear, rr_ptr <= (w+1) mod N_MASTERS, go to IDLE.
- Minimum transaction period: 4 cycles with a same-cycle slave ack.
- Rearbitration after completion costs one IDLE cycle.
- Fairness: with all masters requesting continuously, grants rotate 0,1,...,N-1,0.
- Non-winning requests wait; their outputs stay 0.
- m_rdata slices of non-winners keep their last value.
- Illegal state encoding returns to IDLE with outputs cleared.

Decomposition:
- Package xbar_pkg holds:
  - FSM state encoding localparams (IDLE=2'd0, CONNECT=2'd1, RESP=2'd2).
  - CMD_READ/CMD_WRITE constants.
  - Default width constants shared with the crossbar top.
- Sub-module rr_arbiter #(N):
  - Inputs: req vector, ptr, grant-enable.
  - Outputs: one-hot winner and winner index; combinational search with ptr wrap.
  - rr_ptr register stays in xbar_out_port.

Test Plan:
- Single read: m_req=4'b0100, m_addr slice2=32'h0000_1000, s_ack after 3 cycles with s_rdata=32'hDEAD_BEEF -> s_req high cycle 1, s_addr=32'h1000, m_ack=4'b0100 and rdata slice2=32'hDEAD_BEEF next cycle; grant clears one cycle after m_req[2] drops.
- Write: master 0, cmd=1, wdata=32'hA5A5_0001 -> s_wdata=32'hA5A5_0001, s_cmd=1, m_ack[0] after s_ack, all m_rdata slices unchanged.
- Round-robin: m_req=4'b1111 held, each transaction acked then re-requested -> grant sequence 0001,0010,0100,1000,0001; with m_req=4'b1001 after owner 0 -> next grant 1000.
- Timeout: TMO_W=3, s_ack never asserted -> m_ack[w]=1 and m_err[w]=1 exactly 7 CONNECT cycles after s_req rise; s_req low on the same edge. Second case: s_ack coincides with saturation -> m_err=0.
- Reset mid-CONNECT: assert reset asynchronously between clock edges -> s_req, grant, m_ack, busy are 0 immediately. After release, m_req=4'b0010 -> grant 0010 (rr_ptr restarted at 0).
- s_ack pulse in RESP and illegal-state injection -> no second m_ack; FSM returns to IDLE with outputs 0.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared constants and types for the crossbar output-port controller.
package xbar_pkg;

  localparam int DEF_N_MASTERS = 4;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_TMO_W     = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONNECT = 2'd1;
  localparam logic [1:0] ST_RESP    = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    CONNECT = ST_CONNECT,
    RESP    = ST_RESP
  } state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Folds an index that may have run one lap past n back into 0..n-1.
  function automatic int wrapIdx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/xbar_out_port_if.sv
// Bundle of master-side and slave-side bus signals for one crossbar output port.
// The master modport is the environment (requesting masters plus the slave device);
// the slave modport is the output-port controller serving them.
interface xbar_out_port_if
  import xbar_pkg::*;
#(
  parameter int N_MASTERS = DEF_N_MASTERS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
);

  logic [N_MASTERS-1:0]        m_req;
  logic [N_MASTERS*ADDR_W-1:0] m_addr;
  logic [N_MASTERS-1:0]        m_cmd;
  logic [N_MASTERS*DATA_W-1:0] m_wdata;
  logic [N_MASTERS-1:0]        m_ack;
  logic [N_MASTERS-1:0]        m_err;
  logic [N_MASTERS*DATA_W-1:0] m_rdata;
  logic                        s_req;
  logic [ADDR_W-1:0]           s_addr;
  logic                        s_cmd;
  logic [DATA_W-1:0]           s_wdata;
  logic                        s_ack;
  logic [DATA_W-1:0]           s_rdata;
  logic [N_MASTERS-1:0]        grant;
  logic                        busy;

  modport master (
    output m_req, m_addr, m_cmd, m_wdata, s_ack, s_rdata,
    input  m_ack, m_err, m_rdata, s_req, s_addr, s_cmd, s_wdata, grant, busy
  );

  modport slave (
    input  m_req, m_addr, m_cmd, m_wdata, s_ack, s_rdata,
    output m_ack, m_err, m_rdata, s_req, s_addr, s_cmd, s_wdata, grant, busy
  );

endinterface

// File: rtl/xbar_out_port_rr_arbiter.sv
// Combinational round-robin search: first requester at or above the pointer, wrapping.
module rr_arbiter
  import xbar_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  input  logic             i_en,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_idx
);

  logic [PTR_W-1:0] w_pos;
  logic             w_found;

  // Walk the request vector starting at the pointer and stop at the first hit.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_pos   = '0;
    w_found = 1'b0;
    if (i_en) begin
      for (int k = 0; k < N; k++) begin
        w_pos = PTR_W'(wrapIdx(int'(i_ptr) + k, N));
        if (!w_found && i_req[w_pos]) begin
          o_gnt[w_pos] = 1'b1;
          o_idx        = w_pos;
          w_found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/xbar_out_port.sv
// Output-port controller: arbitrates masters round-robin, forwards the winner to
// the slave, returns ack/rdata to the winner and flags a slave-ack timeout.
module xbar_out_port
  import xbar_pkg::*;
#(
  parameter int N_MASTERS = DEF_N_MASTERS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TMO_W     = DEF_TMO_W
) (
  input  logic             clk,
  input  logic             reset,
  xbar_out_port_if.slave   bus
);

  localparam int PTR_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam logic [TMO_W-1:0] TMO_FIRE = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t                      r_state;
  logic [PTR_W-1:0]            r_ptr;
  logic [PTR_W-1:0]            r_owner;
  logic [TMO_W-1:0]            r_tmo;
  logic [N_MASTERS-1:0]        r_grant;
  logic                        r_sReq;
  logic [ADDR_W-1:0]           r_sAddr;
  logic                        r_sCmd;
  logic [DATA_W-1:0]           r_sWdata;
  logic [N_MASTERS-1:0]        r_mAck;
  logic [N_MASTERS-1:0]        r_mErr;
  logic [N_MASTERS*DATA_W-1:0] r_mRdata;
  logic                        r_busy;

  logic [N_MASTERS-1:0]        w_winGnt;
  logic [PTR_W-1:0]            w_winIdx;
  logic                        w_arbEn;

  assign w_arbEn = (r_state == IDLE);

  rr_arbiter #(.N(N_MASTERS), .PTR_W(PTR_W)) u_arb (
    .i_req (bus.m_req),
    .i_ptr (r_ptr),
    .i_en  (w_arbEn),
    .o_gnt (w_winGnt),
    .o_idx (w_winIdx)
  );

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_tmo    <= '0;
      r_grant  <= '0;
      r_sReq   <= 1'b0;
      r_sAddr  <= '0;
      r_sCmd   <= 1'b0;
      r_sWdata <= '0;
      r_mAck   <= '0;
      r_mErr   <= '0;
      r_mRdata <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|bus.m_req) begin
            r_grant  <= w_winGnt;
            r_owner  <= w_winIdx;
            r_sReq   <= 1'b1;
            r_sAddr  <= bus.m_addr[w_winIdx*ADDR_W +: ADDR_W];
            r_sCmd   <= bus.m_cmd[w_winIdx];
            r_sWdata <= bus.m_wdata[w_winIdx*DATA_W +: DATA_W];
            r_tmo    <= '0;
            r_busy   <= 1'b1;
            r_state  <= CONNECT;
          end
        end
        CONNECT: begin
          r_tmo <= r_tmo + 1'b1;
          if (bus.s_ack) begin
            r_sReq          <= 1'b0;
            r_mAck[r_owner] <= 1'b1;
            r_mErr[r_owner] <= 1'b0;
            if (r_sCmd == CMD_READ) begin
              r_mRdata[r_owner*DATA_W +: DATA_W] <= bus.s_rdata;
            end
            r_state <= RESP;
          end else if (r_tmo == TMO_FIRE) begin
            r_sReq          <= 1'b0;
            r_mAck[r_owner] <= 1'b1;
            r_mErr[r_owner] <= 1'b1;
            r_state         <= RESP;
          end
        end
        RESP: begin
          if (!bus.m_req[r_owner]) begin
            r_mAck  <= '0;
            r_mErr  <= '0;
            r_grant <= '0;
            r_ptr   <= PTR_W'(wrapIdx(int'(r_owner) + 1, N_MASTERS));
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_tmo    <= '0;
          r_grant  <= '0;
          r_sReq   <= 1'b0;
          r_sAddr  <= '0;
          r_sCmd   <= 1'b0;
          r_sWdata <= '0;
          r_mAck   <= '0;
          r_mErr   <= '0;
          r_mRdata <= '0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant   = r_grant;
  assign bus.s_req   = r_sReq;
  assign bus.s_addr  = r_sAddr;
  assign bus.s_cmd   = r_sCmd;
  assign bus.s_wdata = r_sWdata;
  assign bus.m_ack   = r_mAck;
  assign bus.m_err   = r_mErr;
  assign bus.m_rdata = r_mRdata;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_xbar_out_port.sv
// Bench for the crossbar output port: vector table of single transactions plus
// hand-written round-robin, reset, RESP-ack and illegal-state sequences.
`timescale 1ns/1ps
module tb_xbar_out_port;
  import xbar_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 3;
  localparam int TMO_CYCLES = (1 << TW) - 1;

  typedef struct {
    int          master;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ackDelay;
  } vec_t;

  typedef struct {
    logic [N-1:0]      grant;
    logic              err;
    logic [N*DW-1:0]   rdata;
    int                latency;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  xbar_out_port_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  xbar_out_port #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TMO_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  int              testsRun;
  int              testsFailed;
  exp_t            sb[$];
  logic [N*DW-1:0] modelRdata;
  vec_t            vecs[6];

  // Hard stop if something hangs despite the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int master, input logic cmd, input logic [31:0] addr, input logic [31:0] wdata);
    bus.m_addr[master*AW +: AW]  = addr;
    bus.m_wdata[master*DW +: DW] = wdata;
    bus.m_cmd[master]            = cmd;
    bus.m_req[master]            = 1'b1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_grant"}, bus.grant, 0);
    checkOutput({tag, "_mAck"}, bus.m_ack, 0);
    checkOutput({tag, "_mErr"}, bus.m_err, 0);
    checkOutput({tag, "_sReq"}, bus.s_req, 0);
    checkOutput({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic runTxn(input int idx, input vec_t v);
    exp_t            e;
    exp_t            got;
    int              cyc;
    bit              seen;
    bit              timedOut;
    string           tag;
    tag = $sformatf("vec%0d", idx);
    applyStimulus(v.master, v.cmd, v.addr, v.wdata);
    e.grant          = '0;
    e.grant[v.master] = 1'b1;
    timedOut  = (v.ackDelay == 0) || (v.ackDelay > TMO_CYCLES);
    e.err     = timedOut;
    e.latency = timedOut ? TMO_CYCLES : v.ackDelay;
    if (!timedOut && v.cmd == CMD_READ) modelRdata[v.master*DW +: DW] = v.rdata;
    e.rdata = modelRdata;
    sb.push_back(e);
    waitEdge();
    checkOutput({tag, "_sReqRise"}, bus.s_req, 1);
    checkOutput({tag, "_grant"}, bus.grant, e.grant);
    checkOutput({tag, "_sAddr"}, bus.s_addr, v.addr);
    checkOutput({tag, "_sCmd"}, bus.s_cmd, v.cmd);
    checkOutput({tag, "_busy"}, bus.busy, 1);
    if (v.cmd == CMD_WRITE) checkOutput({tag, "_sWdata"}, bus.s_wdata, v.wdata);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      bus.s_ack   = (v.ackDelay != 0) && (cyc + 1 == v.ackDelay);
      bus.s_rdata = v.rdata;
      waitEdge();
      cyc++;
      if (bus.m_ack != '0) seen = 1'b1;
    end
    bus.s_ack = 1'b0;
    got = sb.pop_front();
    if (!seen) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s_ackWait: got no m_ack in %0d cycles, required m_ack", tag, cyc);
    end else begin
      checkOutput({tag, "_mAck"}, bus.m_ack, got.grant);
      checkOutput({tag, "_mErr"}, bus.m_err, got.err ? got.grant : '0);
      checkOutput({tag, "_latency"}, cyc, got.latency);
      checkOutput({tag, "_sReqFall"}, bus.s_req, 0);
      checkOutput({tag, "_mRdata"}, bus.m_rdata, got.rdata);
    end
    bus.m_req[v.master] = 1'b0;
    waitEdge();
    checkIdle({tag, "_release"});
  endtask

  initial begin
    logic [N-1:0] rrExp [6];
    int           cyc;
    int           w;
    testsRun    = 0;
    testsFailed = 0;
    modelRdata  = '0;
    bus.m_req   = '0;
    bus.m_addr  = '0;
    bus.m_cmd   = '0;
    bus.m_wdata = '0;
    bus.s_ack   = 1'b0;
    bus.s_rdata = '0;

    vecs[0] = '{master: 2, cmd: CMD_READ,  addr: 32'h0000_1000, wdata: 32'h0,          rdata: 32'hDEAD_BEEF, ackDelay: 3};
    vecs[1] = '{master: 0, cmd: CMD_WRITE, addr: 32'h0000_2000, wdata: 32'hA5A5_0001, rdata: 32'h1111_1111, ackDelay: 2};
    vecs[2] = '{master: 1, cmd: CMD_READ,  addr: 32'h0000_0030, wdata: 32'h0,          rdata: 32'h1234_5678, ackDelay: 1};
    vecs[3] = '{master: 0, cmd: CMD_READ,  addr: 32'h0000_0044, wdata: 32'h0,          rdata: 32'hCAFE_F00D, ackDelay: TMO_CYCLES};
    vecs[4] = '{master: 2, cmd: CMD_WRITE, addr: 32'h0000_0050, wdata: 32'h5555_AAAA, rdata: 32'h0,          ackDelay: 0};
    vecs[5] = '{master: 3, cmd: CMD_READ,  addr: 32'h0000_0060, wdata: 32'h0,          rdata: 32'h7777_7777, ackDelay: 9};

    reset = 1'b1;
    #12;
    checkIdle("reset");
    checkOutput("reset_mRdata", bus.m_rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    waitEdge();

    for (int i = 0; i < 6; i++) runTxn(i, vecs[i]);

    // Round robin with every master requesting; last vector leaves the pointer at 0.
    rrExp[0] = 4'b0001; rrExp[1] = 4'b0010; rrExp[2] = 4'b0100;
    rrExp[3] = 4'b1000; rrExp[4] = 4'b0001; rrExp[5] = 4'b1000;
    for (int i = 0; i < N; i++) bus.m_cmd[i] = CMD_READ;
    bus.m_req = '1;
    for (int i = 0; i < 6; i++) begin
      cyc = 0;
      while (bus.grant == '0 && cyc < 10) begin
        waitEdge();
        cyc++;
      end
      checkOutput($sformatf("rrGrant%0d", i), bus.grant, rrExp[i]);
      w = (i == 5) ? 3 : i % N;
      bus.s_ack   = 1'b1;
      bus.s_rdata = 32'h100 + i;
      waitEdge();
      bus.s_ack = 1'b0;
      modelRdata[w*DW +: DW] = 32'h100 + i;
      checkOutput($sformatf("rrAck%0d", i), bus.m_ack, rrExp[i]);
      checkOutput($sformatf("rrRdata%0d", i), bus.m_rdata, modelRdata);
      if (i == 5) bus.m_req = '0;
      else bus.m_req[w] = 1'b0;
      waitEdge();
      if (i == 4) bus.m_req = 4'b1001;
      else if (i < 4) bus.m_req[w] = 1'b1;
    end
    checkIdle("rrEnd");

    // Complete one transaction by master 2 so the pointer moves to 3, then reset mid-CONNECT.
    runTxn(6, '{master: 2, cmd: CMD_READ, addr: 32'h0000_0070, wdata: 32'h0, rdata: 32'h0BAD_CAFE, ackDelay: 2});
    applyStimulus(3, CMD_READ, 32'h0000_0080, 32'h0);
    waitEdge();
    waitEdge();
    waitEdge();
    checkOutput("preRst_sReq", bus.s_req, 1);
    #2;
    reset = 1'b1;
    #1;
    checkIdle("asyncRst");
    modelRdata = '0;
    checkOutput("asyncRst_mRdata", bus.m_rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.m_req = 4'b1010;
    waitEdge();
    checkOutput("rstPtr_grant", bus.grant, 4'b0010);
    bus.s_ack   = 1'b1;
    bus.s_rdata = 32'h0000_AAAA;
    waitEdge();
    modelRdata[1*DW +: DW] = 32'h0000_AAAA;
    checkOutput("rstPtr_mAck", bus.m_ack, 4'b0010);

    // Second slave ack while in RESP must be ignored.
    bus.s_rdata = 32'h0000_BBBB;
    waitEdge();
    bus.s_ack = 1'b0;
    checkOutput("respAck_mAck", bus.m_ack, 4'b0010);
    checkOutput("respAck_mRdata", bus.m_rdata, modelRdata);
    checkOutput("respAck_sReq", bus.s_req, 0);
    checkOutput("respAck_busy", bus.busy, 1);
    bus.m_req = '0;
    waitEdge();
    checkIdle("respAckRel");
    waitEdge();
    checkIdle("respAckNoSecond");

    // Corrupt the state register mid-CONNECT; the FSM must fall back to IDLE.
    applyStimulus(2, CMD_READ, 32'h0000_0090, 32'h0);
    waitEdge();
    checkOutput("illegal_pre_grant", bus.grant, 4'b0100);
    bus.m_req = '0;
    dut.r_state = state_t'(2'd3);
    waitEdge();
    checkIdle("illegal");
    waitEdge();
    checkIdle("illegalHold");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
